// File: rtl/qam16_pkg.sv
// rtl/qam16_pkg.sv - 16-QAM level constants, Gray decode helper and symbol type.
package qam16_pkg;

   typedef logic [3:0] sym_t;

   localparam logic signed [2:0] L_M3 = -3'sd3;
   localparam logic signed [2:0] L_M1 = -3'sd1;
   localparam logic signed [2:0] L_P1 = 3'sd1;
   localparam logic signed [2:0] L_P3 = 3'sd3;

   // Gray order keeps adjacent amplitude levels one bit apart.
   function automatic logic signed [2:0] bits2level(input logic [1:0] bits);
      logic signed [2:0] lvl;
      case (bits)
         2'b00:   lvl = L_M3;
         2'b01:   lvl = L_M1;
         2'b11:   lvl = L_P1;
         default: lvl = L_P3;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/qam16_symmap.sv
// rtl/qam16_symmap.sv - combinational Gray 2-bit to signed level mapper (one axis).
module qam16_symmap
   import qam16_pkg::*;
#(
   parameter int SAMP_W = 4
) (
   input  logic        [1:0]        i_bits,
   output logic signed [SAMP_W-1:0] o_level
);

   // Signed size cast sign-extends the 3-bit level to the sample width.
   assign o_level = SAMP_W'(bits2level(i_bits));

endmodule

// File: rtl/qam16_upsampler.sv
// rtl/qam16_upsampler.sv - LFSR 16-QAM symbol source with zero-stuffing upsampler.
// Define QAM_HOLD_EN to replace zero-stuffing with a zero-order hold.
module qam16_upsampler
   import qam16_pkg::*;
#(
   parameter int         UP_FACTOR = 4,
   parameter int         CNT_W     = 4,
   parameter int         SAMP_W    = 4,
   parameter logic [3:0] LFSR_SEED = 4'b0001
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic        [3:0]        sym_q,
   output logic        [CNT_W-1:0]  cnt,
   output logic signed [SAMP_W-1:0] i_sym,
   output logic signed [SAMP_W-1:0] q_sym,
   output logic signed [SAMP_W-1:0] i_up,
   output logic signed [SAMP_W-1:0] q_up,
   output logic                     sym_stb
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UP_FACTOR - 1);

   sym_t                     r_sym;
   logic        [CNT_W-1:0]  r_cnt;
   logic signed [SAMP_W-1:0] r_i_up;
   logic signed [SAMP_W-1:0] r_q_up;
   logic                     r_stb;
   logic signed [SAMP_W-1:0] w_i_sym;
   logic signed [SAMP_W-1:0] w_q_sym;
   logic                     w_phase0;
   logic                     w_last;

   assign w_phase0 = (r_cnt == '0);
   assign w_last   = (r_cnt == CNT_LAST);

   qam16_symmap #(.SAMP_W(SAMP_W)) u_map_i (.i_bits(r_sym[3:2]), .o_level(w_i_sym));
   qam16_symmap #(.SAMP_W(SAMP_W)) u_map_q (.i_bits(r_sym[1:0]), .o_level(w_q_sym));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_sym <= LFSR_SEED;
      end else begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         // x^4+x^3+1, stepped once per symbol period
         if (w_last) begin
            r_sym <= {r_sym[2:0], r_sym[3] ^ r_sym[2]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i_up <= '0;
         r_q_up <= '0;
         r_stb  <= 1'b0;
      end else begin
         r_stb <= w_phase0;
`ifdef QAM_HOLD_EN
         if (w_phase0) begin
            r_i_up <= w_i_sym;
            r_q_up <= w_q_sym;
         end
`else
         r_i_up <= w_phase0 ? w_i_sym : '0;
         r_q_up <= w_phase0 ? w_q_sym : '0;
`endif
      end
   end

   assign sym_q   = r_sym;
   assign cnt     = r_cnt;
   assign i_sym   = w_i_sym;
   assign q_sym   = w_q_sym;
   assign i_up    = r_i_up;
   assign q_up    = r_q_up;
   assign sym_stb = r_stb;

endmodule

// File: tb/tb_qam16_upsampler.sv
// tb/tb_qam16_upsampler.sv - scoreboard bench for qam16_upsampler (honours QAM_HOLD_EN).
module tb_qam16_upsampler;

   localparam int UP = 4;
   localparam int CW = 4;
   localparam int SW = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic        [3:0]    sym_q;
   logic        [CW-1:0] cnt;
   logic signed [SW-1:0] i_sym, q_sym, i_up, q_up;
   logic                 sym_stb;

   typedef struct {
      logic        [3:0]    sym;
      logic        [CW-1:0] cnt;
      logic signed [SW-1:0] i;
      logic signed [SW-1:0] q;
      logic                 stb;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic        [3:0]    m_sym = 4'b0001;
   logic        [CW-1:0] m_cnt = '0;
   logic signed [SW-1:0] m_i = '0;
   logic signed [SW-1:0] m_q = '0;
   logic                 m_stb = 1'b0;

   qam16_upsampler #(
      .UP_FACTOR(UP), .CNT_W(CW), .SAMP_W(SW), .LFSR_SEED(4'b0001)
   ) dut (
      .clk(clk), .reset(reset), .sym_q(sym_q), .cnt(cnt),
      .i_sym(i_sym), .q_sym(q_sym), .i_up(i_up), .q_up(q_up), .sym_stb(sym_stb)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic signed [SW-1:0] gray(input logic [1:0] b);
      case (b)
         2'b00:   return -4'sd3;
         2'b01:   return -4'sd1;
         2'b11:   return 4'sd1;
         default: return 4'sd3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sym = 4'b0001;
      m_cnt = '0;
      m_i   = '0;
      m_q   = '0;
      m_stb = 1'b0;
   endtask

   // One clock edge: model predicts, scoreboard holds it, DUT result is compared after the edge.
   task automatic tick();
      exp_t e;
      exp_t g;
      if (!reset) begin
         model_reset();
      end else begin
         m_stb = (m_cnt == 0);
         if (m_cnt == 0) begin
            m_i = gray(m_sym[3:2]);
            m_q = gray(m_sym[1:0]);
         end else begin
`ifndef QAM_HOLD_EN
            m_i = '0;
            m_q = '0;
`endif
         end
         if (m_cnt == CW'(UP - 1)) begin
            m_sym = {m_sym[2:0], m_sym[3] ^ m_sym[2]};
            m_cnt = '0;
         end else begin
            m_cnt = m_cnt + 1'b1;
         end
      end
      e.sym = m_sym; e.cnt = m_cnt; e.i = m_i; e.q = m_q; e.stb = m_stb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("sym_q", 32'(sym_q), 32'(g.sym));
      chk("cnt", 32'(cnt), 32'(g.cnt));
      chk("i_up", i_up, g.i);
      chk("q_up", q_up, g.q);
      chk("sym_stb", 32'(sym_stb), 32'(g.stb));
      chk("i_sym", i_sym, gray(g.sym[3:2]));
      chk("q_sym", q_sym, gray(g.sym[1:0]));
   endtask

   logic [3:0]  first_sym;
   logic [15:0] seen;

   initial begin
      // reset held for three edges
      reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) tick();

      // first and second symbol after release
      reset = 1'b1;
      tick();
      chk("first_i", i_up, -4'sd3);
      chk("first_q", q_up, -4'sd1);
      chk("first_stb", 32'(sym_stb), 1);
      for (int k = 0; k < 3; k++) tick();
      chk("sym2_state", 32'(sym_q), 32'(4'b0010));
      tick();
      chk("sym2_i", i_up, -4'sd3);
      chk("sym2_q", q_up, 4'sd3);
      chk("sym2_stb", 32'(sym_stb), 1);
      for (int k = 0; k < 3; k++) tick();

      // asynchronous reset in the middle of a symbol
      tick();
      tick();
      chk("mid_cnt_before", 32'(cnt), 2);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("mid_sym", 32'(sym_q), 1);
      chk("mid_cnt", 32'(cnt), 0);
      chk("mid_i", i_up, 0);
      chk("mid_q", q_up, 0);
      chk("mid_stb", 32'(sym_stb), 0);
      @(negedge clk);
      tick();
      reset = 1'b1;
      tick();
      chk("resume_i", i_up, -4'sd3);
      chk("resume_q", q_up, -4'sd1);
      for (int k = 0; k < 3; k++) tick();
      tick();
      chk("resume2_q", q_up, 4'sd3);

      // LFSR period from a fresh seed
      reset = 1'b0;
      tick();
      reset = 1'b1;
      first_sym = sym_q;
      chk("period_seed", 32'(first_sym), 1);
      seen = '0;
      seen[sym_q] = 1'b1;
      for (int s = 1; s < 15; s++) begin
         for (int k = 0; k < UP; k++) tick();
         seen[sym_q] = 1'b1;
      end
      chk("period_mask", 32'(seen), 32'(16'hFFFE));
      for (int k = 0; k < UP; k++) tick();
      chk("period_wrap", 32'(sym_q), 1);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
